// File: rtl/morsecode_transmitter.sv
// Serialises a right-aligned Morse pattern onto an LED, one bit per TICK_DIV-cycle time unit, LSB first.
// Optional macro MORSE_LETTER_GAP_EN appends a two-unit dark gap before the completion pulse.
module morsecode_transmitter #(
   parameter int unsigned TICK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  morsecode_length,
   input  logic [12:0] morsecode_shiftreg,
   output logic        light,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CNT_W = 25;
   localparam int unsigned PAT_W = 13;
   localparam int unsigned LEN_W = 4;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(PAT_W);

`ifdef MORSE_LETTER_GAP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PAT_W-1:0]   shift_q, shift_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               light_q, light_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef MORSE_LETTER_GAP_EN
   logic               gap_unit_q, gap_unit_d;
`endif

   // State and datapath registers; outputs are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         len_q      <= '0;
         light_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MORSE_LETTER_GAP_EN
         gap_unit_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         len_q      <= len_d;
         light_q    <= light_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef MORSE_LETTER_GAP_EN
         gap_unit_q <= gap_unit_d;
`endif
      end
   end

   // Next-state, unit timing and output decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      len_d      = len_q;
`ifdef MORSE_LETTER_GAP_EN
      gap_unit_d = gap_unit_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = morsecode_shiftreg;
               len_d   = (morsecode_length > LEN_MAX) ? LEN_MAX : morsecode_length;
               cnt_d   = '0;
               state_d = (morsecode_length == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == TICK_LAST) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               len_d   = LEN_W'(len_q - LEN_W'(1));
               if (len_q == LEN_W'(1)) begin
`ifdef MORSE_LETTER_GAP_EN
                  state_d    = GAP;
                  gap_unit_d = 1'b0;
`else
                  state_d    = DONE;
`endif
               end
            end else begin
               cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
         end
`ifdef MORSE_LETTER_GAP_EN
         // Two dark units, tracked by one extra bit so the counter stays one unit wide
         GAP: begin
            if (cnt_q == TICK_LAST) begin
               cnt_d = '0;
               if (gap_unit_q) begin
                  state_d = DONE;
               end else begin
                  gap_unit_d = 1'b1;
               end
            end else begin
               cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      light_d = (state_d == SHIFT) && shift_d[0];
`ifdef MORSE_LETTER_GAP_EN
      busy_d  = (state_d == SHIFT) || (state_d == GAP);
`else
      busy_d  = (state_d == SHIFT);
`endif
      done_d  = (state_d == DONE);
   end

   assign light = light_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_morsecode_transmitter.sv
// Directed bench for morsecode_transmitter at TICK_DIV=4; expectations follow MORSE_LETTER_GAP_EN.
module tb_morsecode_transmitter;

   localparam int TICK = 4;
`ifdef MORSE_LETTER_GAP_EN
   localparam int GAPC = 2 * TICK;
`else
   localparam int GAPC = 0;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  len;
   logic [12:0] pat;
   logic        light;
   logic        busy;
   logic        done;

   int checks;
   int errors;

   morsecode_transmitter #(.TICK_DIV(TICK)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .morsecode_length   (len),
      .morsecode_shiftreg (pat),
      .light              (light),
      .busy               (busy),
      .done               (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; on return, outputs reflect that edge and inputs set next apply to the following edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; len = 4'd3; pat = 13'b010;
      for (int i = 0; i < 3; i++) begin
         step();
         checks += 3;
         if (light !== 1'b0) begin errors++; $display("FAIL reset_light i=%0d got=%b exp=0", i, light); end
         if (busy  !== 1'b0) begin errors++; $display("FAIL reset_busy i=%0d got=%b exp=0", i, busy); end
         if (done  !== 1'b0) begin errors++; $display("FAIL reset_done i=%0d got=%b exp=0", i, done); end
      end
      rst = 1'b0;
      step();
      checks += 2;
      if (busy  !== 1'b1) begin errors++; $display("FAIL reset_first_start busy got=%b exp=1", busy); end
      if (light !== 1'b0) begin errors++; $display("FAIL reset_first_start light got=%b exp=0", light); end
      rst = 1'b1; start = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_letter_e();
      logic [12:0] p;
      logic exp_l, exp_b, exp_d;
      p = 13'b010;
      pat = p; len = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 15 + GAPC; c++) begin
         exp_l = (c <= 3 * TICK) ? p[(c - 1) / TICK] : 1'b0;
         exp_b = (c <= 3 * TICK + GAPC);
         exp_d = (c == 3 * TICK + GAPC + 1);
         checks += 3;
         if (light !== exp_l) begin errors++; $display("FAIL e_light c=%0d got=%b exp=%b", c, light, exp_l); end
         if (busy  !== exp_b) begin errors++; $display("FAIL e_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
         if (done  !== exp_d) begin errors++; $display("FAIL e_done c=%0d got=%b exp=%b", c, done, exp_d); end
         step();
      end
   endtask

   task automatic test_input_change();
      logic [12:0] p;
      logic exp_l, exp_b, exp_d;
      int n_done;
      p = 13'b0111010;
      n_done = 0;
      pat = p; len = 4'd7; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 7 * TICK + GAPC + 4; c++) begin
         exp_l = (c <= 7 * TICK) ? p[(c - 1) / TICK] : 1'b0;
         exp_b = (c <= 7 * TICK + GAPC);
         exp_d = (c == 7 * TICK + GAPC + 1);
         if (done === 1'b1) n_done++;
         checks += 3;
         if (light !== exp_l) begin errors++; $display("FAIL a_light c=%0d got=%b exp=%b", c, light, exp_l); end
         if (busy  !== exp_b) begin errors++; $display("FAIL a_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
         if (done  !== exp_d) begin errors++; $display("FAIL a_done c=%0d got=%b exp=%b", c, done, exp_d); end
         if (c == 2) begin pat = 13'b01010101; len = 4'd8; end
         start = (c == 6);
         step();
      end
      checks++;
      if (n_done != 1) begin errors++; $display("FAIL a_done_count got=%0d exp=1", n_done); end
   endtask

   task automatic test_zero_length();
      logic exp_d;
      pat = 13'b1111; len = 4'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         exp_d = (c == 1);
         checks += 3;
         if (light !== 1'b0)  begin errors++; $display("FAIL zero_light c=%0d got=%b exp=0", c, light); end
         if (busy  !== 1'b0)  begin errors++; $display("FAIL zero_busy c=%0d got=%b exp=0", c, busy); end
         if (done  !== exp_d) begin errors++; $display("FAIL zero_done c=%0d got=%b exp=%b", c, done, exp_d); end
         step();
      end
   endtask

   task automatic test_clamp();
      logic [12:0] p;
      logic exp_l, exp_b, exp_d;
      p = 13'b1011101011101;
      pat = p; len = 4'd15; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 13 * TICK + GAPC + 3; c++) begin
         exp_l = (c <= 13 * TICK) ? p[(c - 1) / TICK] : 1'b0;
         exp_b = (c <= 13 * TICK + GAPC);
         exp_d = (c == 13 * TICK + GAPC + 1);
         checks += 3;
         if (light !== exp_l) begin errors++; $display("FAIL clamp_light c=%0d got=%b exp=%b", c, light, exp_l); end
         if (busy  !== exp_b) begin errors++; $display("FAIL clamp_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
         if (done  !== exp_d) begin errors++; $display("FAIL clamp_done c=%0d got=%b exp=%b", c, done, exp_d); end
         step();
      end
   endtask

   task automatic test_reset_abort();
      logic [12:0] p;
      logic exp_l, exp_b, exp_d;
      int d;
      p = 13'b1011101011101;
      pat = p; len = 4'd13; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 23 + 13 * TICK + GAPC + 2; c++) begin
         if (c <= 20) begin
            exp_l = p[(c - 1) / TICK]; exp_b = 1'b1; exp_d = 1'b0;
         end else if (c <= 23) begin
            exp_l = 1'b0; exp_b = 1'b0; exp_d = 1'b0;
         end else begin
            d = c - 23;
            exp_l = (d <= 13 * TICK) ? p[(d - 1) / TICK] : 1'b0;
            exp_b = (d <= 13 * TICK + GAPC);
            exp_d = (d == 13 * TICK + GAPC + 1);
         end
         checks += 3;
         if (light !== exp_l) begin errors++; $display("FAIL abort_light c=%0d got=%b exp=%b", c, light, exp_l); end
         if (busy  !== exp_b) begin errors++; $display("FAIL abort_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
         if (done  !== exp_d) begin errors++; $display("FAIL abort_done c=%0d got=%b exp=%b", c, done, exp_d); end
         rst   = (c == 20);
         start = (c == 23);
         step();
      end
      rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [12:0] p;
      logic exp_l, exp_b, exp_d;
      int period;
      int ph;
      p = 13'b010;
      period = 3 * TICK + GAPC + 2;
      pat = p; len = 4'd3; start = 1'b1;
      step();
      for (int c = 1; c <= 2 * period; c++) begin
         ph = (c - 1) % period;
         exp_l = (ph < 3 * TICK) ? p[ph / TICK] : 1'b0;
         exp_b = (ph < 3 * TICK + GAPC);
         exp_d = (ph == 3 * TICK + GAPC);
         checks += 3;
         if (light !== exp_l) begin errors++; $display("FAIL b2b_light c=%0d got=%b exp=%b", c, light, exp_l); end
         if (busy  !== exp_b) begin errors++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
         if (done  !== exp_d) begin errors++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, exp_d); end
         if (c > period) start = 1'b0;
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; len = '0; pat = '0;
      @(negedge clk);
      test_reset();
      test_letter_e();
      test_input_change();
      test_zero_length();
      test_clamp();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
